// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared state encoding and default widths for the animation sequencer
//
// Purpose : common types for anim_sequencer and its bench.
// Contents: anim_state_e (IDLE, SHOW, WAIT, DONE), ANIM_FRAME_W, ANIM_HOLD_W.
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } anim_state_e;

    localparam int ANIM_FRAME_W = 4;
    localparam int ANIM_HOLD_W  = 8;

endpackage

// File: rtl/anim_sequencer_if.sv
// rtl/anim_sequencer_if.sv - frame index handshake between sequencer and sprite fetch
//
// Purpose : carries the frame index with a valid/ready handshake.
// Signals : frame_idx   - frame index presented by the sequencer
//           frame_valid - frame_idx is new and awaits acceptance
//           frame_ready - sprite-fetch stage accepts frame_idx
// Modports: master (sequencer side), slave (sprite-fetch side).
interface anim_sequencer_if #(
    parameter int FRAME_W = anim_pkg::ANIM_FRAME_W
) ();

    logic [FRAME_W-1:0] frame_idx;
    logic               frame_valid;
    logic               frame_ready;

    modport master (
        output frame_idx,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_idx,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/anim_sequencer_tick_detect.sv
// rtl/anim_sequencer_tick_detect.sv - change detector turning a free-running count into tick pulses
//
// Purpose : flags every cycle in which the count differs from its value one
//           cycle earlier. Any change counts, including a wrap to zero.
// Ports   : clk, rst (async, active high)
//           cnt_in - free-running count from the counter stage
//           tick   - high for each cycle in which cnt_in changed
module tick_change_detect #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             tick
);

    logic [CNT_W-1:0] hist_q;
    logic [CNT_W-1:0] hist_d;

    // History follows the count every cycle, whatever the consumer is doing.
    always_comb begin
        hist_d = cnt_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign tick = (cnt_in != hist_q);

endmodule

// File: rtl/anim_sequencer.sv
// rtl/anim_sequencer.sv - steps animation frames on counter ticks and hands them to sprite fetch
//
// Purpose : shows frame 0..num_frames, holding each for max(hold_ticks,1)
//           ticks after the renderer accepts it; plays once or loops.
// Ports   : clk, rst (async, active high)
//           tick_cnt   - prescaled count; any change is one tick
//           start/stop - one-cycle playback requests (stop wins)
//           loop_en, num_frames, hold_ticks - sampled on start and on each advance
//           frm        - master side of the frame handshake
//           busy       - high outside IDLE
//           done       - one-cycle pulse at the end of a play-once sequence
// Option  : ANIM_PINGPONG_EN adds input pingpong for back-and-forth playback.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int FRAME_W = ANIM_FRAME_W,
    parameter int HOLD_W  = ANIM_HOLD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        tick_cnt,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [FRAME_W-1:0] num_frames,
    input  logic [HOLD_W-1:0]  hold_ticks,
`ifdef ANIM_PINGPONG_EN
    input  logic               pingpong,
`endif
    anim_sequencer_if.master   frm,
    output logic               busy,
    output logic               done
);

    anim_state_e        state_q, state_d;
    logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
    logic               frame_valid_q, frame_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0]  hold_cfg_q, hold_cfg_d;

    logic               tick;
    logic [HOLD_W-1:0]  hold_target;
    logic [HOLD_W:0]    hold_next;
    logic [FRAME_W-1:0] adv_idx;
    anim_state_e        adv_state;

`ifdef ANIM_PINGPONG_EN
    logic               dir_q, dir_d, adv_dir;
`endif

    tick_change_detect #(
        .CNT_W (32)
    ) u_tick_detect (
        .clk    (clk),
        .rst    (rst),
        .cnt_in (tick_cnt),
        .tick   (tick)
    );

    // A hold of zero would never match the incremented count, so it becomes one.
    assign hold_target = (hold_cfg_q == '0) ? {{(HOLD_W-1){1'b0}}, 1'b1} : hold_cfg_q;
    assign hold_next   = {1'b0, hold_cnt_q} + {{HOLD_W{1'b0}}, 1'b1};

    // Where the sequence goes once the current frame's hold expires. The
    // last-frame test precedes the increment, so frame_idx never overflows.
    always_comb begin
        adv_idx   = frame_idx_q;
        adv_state = SHOW;
`ifdef ANIM_PINGPONG_EN
        adv_dir   = dir_q;
        if (dir_q) begin
            if (frame_idx_q != '0) begin
                adv_idx = frame_idx_q - 1'b1;
            end else if (loop_en) begin
                // Turn around at frame 0; frame 0 itself is not repeated.
                adv_dir = 1'b0;
                adv_idx = (num_frames != '0) ? {{(FRAME_W-1){1'b0}}, 1'b1} : '0;
            end else begin
                adv_state = DONE;
            end
        end else if (frame_idx_q < num_frames) begin
            adv_idx = frame_idx_q + 1'b1;
        end else if (pingpong && (num_frames != '0)) begin
            adv_dir = 1'b1;
            adv_idx = frame_idx_q - 1'b1;
        end else if (loop_en) begin
            adv_idx = '0;
        end else begin
            adv_state = DONE;
        end
`else
        if (frame_idx_q < num_frames) begin
            adv_idx = frame_idx_q + 1'b1;
        end else if (loop_en) begin
            adv_idx = '0;
        end else begin
            adv_state = DONE;
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        frame_idx_d   = frame_idx_q;
        frame_valid_d = frame_valid_q;
        hold_cnt_d    = hold_cnt_q;
        hold_cfg_d    = hold_cfg_q;
        done_d        = 1'b0;
`ifdef ANIM_PINGPONG_EN
        dir_d         = dir_q;
`endif
        if ((state_q != IDLE) && stop) begin
            // Abort keeps the current index and suppresses the done pulse.
            state_d       = IDLE;
            frame_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d       = SHOW;
                        frame_idx_d   = '0;
                        frame_valid_d = 1'b1;
                        hold_cnt_d    = '0;
                        hold_cfg_d    = hold_ticks;
`ifdef ANIM_PINGPONG_EN
                        dir_d         = 1'b0;
`endif
                    end
                end
                SHOW: begin
                    // Ticks here are ignored: a stalled renderer stretches the frame.
                    if (frm.frame_ready) begin
                        state_d       = WAIT;
                        frame_valid_d = 1'b0;
                        hold_cnt_d    = '0;
                    end
                end
                WAIT: begin
                    if (tick) begin
                        hold_cnt_d = hold_next[HOLD_W-1:0];
                        if (hold_next == {1'b0, hold_target}) begin
                            state_d       = adv_state;
                            frame_idx_d   = adv_idx;
                            frame_valid_d = (adv_state == SHOW);
                            done_d        = (adv_state == DONE);
                            hold_cfg_d    = hold_ticks;
`ifdef ANIM_PINGPONG_EN
                            dir_d         = adv_dir;
`endif
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            frame_idx_q   <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hold_cnt_q    <= '0;
            hold_cfg_q    <= '0;
`ifdef ANIM_PINGPONG_EN
            dir_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            frame_idx_q   <= frame_idx_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_cfg_q    <= hold_cfg_d;
`ifdef ANIM_PINGPONG_EN
            dir_q         <= dir_d;
`endif
        end
    end

    assign frm.frame_idx   = frame_idx_q;
    assign frm.frame_valid = frame_valid_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// tb/tb_anim_sequencer.sv - self-checking bench for anim_sequencer (ANIM_PINGPONG_EN optional)
module tb_anim_sequencer;
    import anim_pkg::*;

    localparam int FW = ANIM_FRAME_W;
    localparam int HW = ANIM_HOLD_W;
    localparam logic [31:0] TICK_MOD = 32'd100000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   tick_cnt;
    logic          start, stop, loop_en;
    logic [FW-1:0] num_frames;
    logic [HW-1:0] hold_ticks;
    logic          busy, done;
`ifdef ANIM_PINGPONG_EN
    logic          pingpong;
`endif

    anim_sequencer_if #(.FRAME_W(FW)) frm ();

    anim_sequencer #(.FRAME_W(FW), .HOLD_W(HW)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_cnt   (tick_cnt),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .num_frames (num_frames),
        .hold_ticks (hold_ticks),
`ifdef ANIM_PINGPONG_EN
        .pingpong   (pingpong),
`endif
        .frm        (frm),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] hist_model;
    bit          tick_e;
    int          m_idx_g;
    int          acc_log[$];
    int          done_seen;

    // Advance one clock; tick_e tells whether the edge just taken saw a count change.
    task automatic step();
        tick_e = (tick_cnt != hist_model);
        @(posedge clk);
        hist_model = rst ? 32'd0 : tick_cnt;
        #1;
    endtask

    task automatic bump_tick();
        tick_cnt = (tick_cnt == TICK_MOD - 32'd1) ? 32'd0 : tick_cnt + 32'd1;
    endtask

    // k-th frame shown after start, straight from the playback rules.
    function automatic int seq_idx(input int k, input int n, input bit pp);
        int p;
        if (pp && n > 0) begin
            p = k % (2 * n);
            return (p <= n) ? p : 2 * n - p;
        end
        return k % (n + 1);
    endfunction

    task automatic run_seq(input int n, input int hold, input bit lp, input bit pp,
                           input int n_acc, input int tick_period, input int tick_pct,
                           input int ready_pct, input string name);
        int pos, ticks, hold_eff, total, err0;
        bit m_valid, m_wait, m_done, m_busy, start_e, stop_e, ready_e, stop_sent, finished, do_tick;
        logic [FW-1:0] e_idx;
        hold_eff  = (hold == 0) ? 1 : hold;
        total     = (pp && n > 0) ? 2 * n + 1 : n + 1;
        pos = 0; ticks = 0; m_valid = 0; m_wait = 0; m_done = 0; m_busy = 0;
        stop_sent = 0; finished = 0; err0 = errors; done_seen = 0;
        acc_log.delete();
        num_frames = FW'(n); hold_ticks = HW'(hold); loop_en = lp;
`ifdef ANIM_PINGPONG_EN
        pingpong = pp;
`endif
        start = 1'b1; stop = 1'b0;
        frm.frame_ready = ($urandom_range(99) < ready_pct);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            start_e = start; stop_e = stop; ready_e = frm.frame_ready;
            if (frm.frame_valid && frm.frame_ready) acc_log.push_back(int'(frm.frame_idx));
            step();
            if (done) done_seen++;
            if (m_busy && stop_e) begin
                m_valid = 0; m_wait = 0; m_done = 0; m_busy = 0;
            end else if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (!m_busy && start_e) begin
                m_valid = 1; m_busy = 1; m_idx_g = 0;
            end else if (m_valid && ready_e) begin
                m_valid = 0; m_wait = 1; ticks = 0; pos++;
            end else if (m_wait && tick_e) begin
                ticks++;
                if (ticks == hold_eff) begin
                    m_wait = 0;
                    if (lp || pos < total) begin
                        m_valid = 1; m_idx_g = seq_idx(pos, n, pp);
                    end else begin
                        m_done = 1;
                    end
                end
            end
            e_idx = m_idx_g[FW-1:0];
            checks++;
            if (frm.frame_valid !== m_valid) begin
                errors++; $display("FAIL %s frame_valid cyc %0d: got %b want %b", name, cyc, frm.frame_valid, m_valid);
            end
            checks++;
            if (frm.frame_idx !== e_idx) begin
                errors++; $display("FAIL %s frame_idx cyc %0d: got %0d want %0d", name, cyc, frm.frame_idx, e_idx);
            end
            checks++;
            if (busy !== m_busy) begin
                errors++; $display("FAIL %s busy cyc %0d: got %b want %b", name, cyc, busy, m_busy);
            end
            checks++;
            if (done !== m_done) begin
                errors++; $display("FAIL %s done cyc %0d: got %b want %b", name, cyc, done, m_done);
            end
            if (errors != err0) break;
            if (!m_busy) begin
                finished = 1;
                break;
            end
            start = 1'b0; stop = 1'b0;
            if (lp && pos >= n_acc && !stop_sent) begin
                stop = 1'b1; stop_sent = 1;
            end
            frm.frame_ready = ($urandom_range(99) < ready_pct);
            if (tick_period != 0) do_tick = ((cyc % tick_period) == tick_period - 1);
            else                  do_tick = ($urandom_range(99) < tick_pct);
            if (do_tick) bump_tick();
        end
        start = 1'b0; stop = 1'b0;
        if (!finished && errors == err0) begin
            checks++; errors++;
            $display("FAIL %s timeout: busy=%b, required return to idle", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_cnt = 32'd0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        num_frames = '0; hold_ticks = '0; frm.frame_ready = 1'b0; hist_model = 32'd0;
`ifdef ANIM_PINGPONG_EN
        pingpong = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;
        m_idx_g = 0;
        checks++;
        if ({frm.frame_valid, busy, done} !== 3'b000 || frm.frame_idx !== '0) begin
            errors++; $display("FAIL reset outputs: valid/busy/done=%b%b%b idx=%0d want 000 idx 0",
                               frm.frame_valid, busy, done, frm.frame_idx);
        end
        repeat (3) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset idle_hold busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int exp_seq[3] = '{0, 1, 2};
        run_seq(2, 3, 1'b0, 1'b0, 0, 4, 0, 100, "basic");
        checks++;
        if (acc_log.size() != 3) begin
            errors++; $display("FAIL basic frame_count: got %0d want 3", acc_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_log[i] != exp_seq[i]) begin
                    errors++; $display("FAIL basic seq[%0d]: got %0d want %0d", i, acc_log[i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (done_seen != 1) begin
            errors++; $display("FAIL basic done_pulses: got %0d want 1", done_seen);
        end
    endtask

    task automatic test_loop_wrap();
        int exp_seq[4] = '{0, 1, 0, 1};
        for (int off = 0; off < 2; off++) begin
            tick_cnt = 32'd99990 + 32'(off);
            run_seq(1, 1, 1'b1, 1'b0, 8, 1, 0, 100, "loop_wrap");
            checks++;
            if (acc_log.size() < 4) begin
                errors++; $display("FAIL loop_wrap frame_count: got %0d want >=4", acc_log.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (acc_log[i] != exp_seq[i]) begin
                        errors++; $display("FAIL loop_wrap seq[%0d]: got %0d want %0d", i, acc_log[i], exp_seq[i]);
                    end
                end
            end
            checks++;
            if (done_seen != 0) begin
                errors++; $display("FAIL loop_wrap done_pulses: got %0d want 0", done_seen);
            end
        end
    endtask

    task automatic test_backpressure();
        int ticks;
        bit seen;
        num_frames = FW'(1); hold_ticks = HW'(2); loop_en = 1'b0;
        frm.frame_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) bump_tick();
            step();
            checks++;
            if (frm.frame_valid !== 1'b1 || frm.frame_idx !== '0) begin
                errors++; $display("FAIL backpressure stable cyc %0d: valid=%b idx=%0d want 1/0",
                                   i, frm.frame_valid, frm.frame_idx);
            end
        end
        frm.frame_ready = 1'b1; bump_tick();
        step();
        frm.frame_ready = 1'b0;
        checks++;
        if (frm.frame_valid !== 1'b0) begin
            errors++; $display("FAIL backpressure accept valid: got %b want 0", frm.frame_valid);
        end
        ticks = 0; seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (i % 3 == 2) bump_tick();
            step();
            if (tick_e) ticks++;
            checks++;
            if (ticks < 2) begin
                if (frm.frame_valid !== 1'b0) begin
                    errors++; $display("FAIL backpressure early_frame after %0d ticks: valid=%b want 0", ticks, frm.frame_valid);
                end
            end else begin
                seen = 1;
                if (frm.frame_valid !== 1'b1 || frm.frame_idx !== FW'(1)) begin
                    errors++; $display("FAIL backpressure next_frame: valid=%b idx=%0d want 1/1", frm.frame_valid, frm.frame_idx);
                end
            end
        end
        if (!seen) begin
            checks++; errors++; $display("FAIL backpressure hold_timeout: ticks=%0d want 2", ticks);
        end
        frm.frame_ready = 1'b1;
        for (int i = 0; i < 40 && busy; i++) begin
            bump_tick();
            step();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL backpressure end busy: got %b want 0", busy);
        end
        m_idx_g = 1;
    endtask

    task automatic test_stop_start();
        bit found;
        num_frames = FW'(3); hold_ticks = HW'(4); loop_en = 1'b0;
        frm.frame_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            bump_tick();
            step();
            if (frm.frame_valid && frm.frame_idx == FW'(1)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL stop_start reach_frame1: idx=%0d want 1", frm.frame_idx);
        end
        step();
        bump_tick();
        step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || frm.frame_valid !== 1'b0 || done !== 1'b0 || frm.frame_idx !== FW'(1)) begin
            errors++; $display("FAIL stop_start abort: busy=%b valid=%b done=%b idx=%0d want 0/0/0/1",
                               busy, frm.frame_valid, done, frm.frame_idx);
        end
        for (int i = 0; i < 5; i++) begin
            bump_tick();
            step();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL stop_start after cyc %0d: busy=%b done=%b want 0/0", i, busy, done);
            end
        end
        m_idx_g = 1;
    endtask

    task automatic test_async_reset();
        bit found;
        num_frames = FW'(2); hold_ticks = HW'(1); loop_en = 1'b1;
        frm.frame_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            bump_tick();
            step();
            if (frm.frame_valid && frm.frame_idx == FW'(1)) found = 1;
        end
        frm.frame_ready = 1'b0;
        step();
        checks++;
        if (!found || frm.frame_valid !== 1'b1 || frm.frame_idx !== FW'(1)) begin
            errors++; $display("FAIL async_reset setup: valid=%b idx=%0d want 1/1", frm.frame_valid, frm.frame_idx);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({frm.frame_valid, busy, done} !== 3'b000 || frm.frame_idx !== '0) begin
            errors++; $display("FAIL async_reset outputs: valid/busy/done=%b%b%b idx=%0d want 000 idx 0",
                               frm.frame_valid, busy, done, frm.frame_idx);
        end
        step();
        rst = 1'b0;
        m_idx_g = 0;
        step();
        checks++;
        if (busy !== 1'b0 || frm.frame_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset post: busy=%b valid=%b want 0/0", busy, frm.frame_valid);
        end
    endtask

`ifdef ANIM_PINGPONG_EN
    task automatic test_pingpong();
        int exp_seq[6] = '{0, 1, 2, 1, 0, 1};
        run_seq(2, 1, 1'b1, 1'b1, 6, 0, 70, 80, "pingpong");
        checks++;
        if (acc_log.size() < 6) begin
            errors++; $display("FAIL pingpong frame_count: got %0d want >=6", acc_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (acc_log[i] != exp_seq[i]) begin
                    errors++; $display("FAIL pingpong seq[%0d]: got %0d want %0d", i, acc_log[i], exp_seq[i]);
                end
            end
        end
        run_seq(3, 2, 1'b0, 1'b1, 0, 0, 60, 70, "pingpong_once");
    endtask
`endif

    task automatic test_random();
        int n, hold, n_acc, tpct, rpct;
        bit lp, pp;
        for (int it = 0; it < 8; it++) begin
            n     = (it == 0) ? 15 : $urandom_range(15);
            hold  = (it == 1) ? 0 : $urandom_range(3);
            lp    = (it == 0) ? 1'b0 : 1'($urandom_range(1));
            pp    = 1'b0;
`ifdef ANIM_PINGPONG_EN
            pp    = 1'($urandom_range(1));
`endif
            n_acc = $urandom_range(20, 5);
            tpct  = $urandom_range(90, 30);
            rpct  = $urandom_range(100, 40);
            run_seq(n, hold, lp, pp, n_acc, 0, tpct, rpct, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop_wrap();
        test_backpressure();
        test_stop_start();
        test_async_reset();
`ifdef ANIM_PINGPONG_EN
        test_pingpong();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
- Downstream consumer of the 32-bit prescaled tick counter output.
- Turns counter value changes into animation-frame steps for the sprite/scene renderer.
- Holds each frame for a programmable number of ticks; plays once or loops.
- Presents each new frame index to the sprite-fetch stage over a valid/ready handshake.

Parameters:
- FRAME_W, 4, width of the frame index; at most 2^FRAME_W frames.
- HOLD_W, 8, width of the per-frame hold-tick count.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tick_cnt  input  32  free-running prescaled count from the counter stage.
- start  input  1  one-cycle request to begin playback from frame 0.
- stop  input  1  one-cycle abort request; returns the block to IDLE.
- loop_en  input  1  1 = restart at frame 0 after the last frame; 0 = play once.
- num_frames  input  FRAME_W  index of the last frame (last = num_frames; 0 = single frame).
- hold_ticks  input  HOLD_W  ticks to hold each frame after acceptance; 0 is treated as 1.
- frame_idx  output  FRAME_W  current frame index.
- frame_valid  output  1  frame_idx is new and awaits acceptance.
- frame_ready  input  1  sprite-fetch stage accepts frame_idx.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a play-once sequence completes.

Behaviour:
- Reset (async, rst=1): state IDLE, frame_idx=0, frame_valid=0, busy=0, done=0, hold counter=0, tick_cnt history register=0.
- Tick detection: tick = (tick_cnt != registered previous tick_cnt). The history register updates every cycle, including in IDLE. A wrap from MAX-1 to 0 counts as a tick. At most one tick per cycle.
- Configuration inputs (num_frames, hold_ticks, loop_en) are sampled on start and at each frame advance, never mid-hold.
- IDLE:
  - start: frame_idx<=0, hold counter<=0, go to SHOW next cycle.
- SHOW:
  - frame_valid=1. frame_idx and frame_valid stay stable until frame_valid & frame_ready.
  - On acceptance: frame_valid<=0, hold counter<=0, go to WAIT.
  - Ticks seen in SHOW are discarded, so the frame lasts longer while the renderer stalls.
- WAIT:
  - Each tick increments the hold counter.
  - When a tick makes the count equal to max(hold_ticks,1), advance:
    - frame_idx < num_frames: frame_idx+1, go to SHOW.
    - frame_idx == num_frames and loop_en: frame_idx<=0, go to SHOW.
    - Otherwise: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. frame_idx keeps the last value.
- Latency: start to frame_valid is 1 cycle. Qualifying tick to next frame_valid is 1 cycle.
- stop has priority over every other event in any non-IDLE state: next state IDLE, frame_valid<=0, no done pulse, frame_idx kept.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- frame_idx wrap: if num_frames = 2^FRAME_W-1, the increment never overflows because the last-frame check comes first.
- Reset mid-operation: immediate return to reset values. A pending handshake is dropped.

Optional Feature:
- Macro ANIM_PINGPONG_EN.
- Defined: adds input pingpong (1 bit) and an internal direction bit, cleared on reset and on start.
  - With pingpong=1 and loop_en=1, on reaching num_frames the direction reverses and the index steps down to 0, then reverses again.
  - The frames at each end are shown once per turn.
  - With pingpong=1 and loop_en=0: done after returning to frame 0.
- Not defined: no port, no direction logic; forward playback only.

Decomposition:
- Package anim_pkg holds:
  - state enum: IDLE, SHOW, WAIT, DONE.
  - default widths ANIM_FRAME_W=4, ANIM_HOLD_W=8.
- One sub-module, tick_change_detect: a 32-bit history register and comparator that outputs the one-cycle tick pulse. It is reusable by other counter consumers.

Test Plan:
- Basic play-once: num_frames=2, hold_ticks=3, loop_en=0, frame_ready tied 1, tick every 4 cycles.
  - Expect frame_idx 0,1,2, each frame_valid pulse 3 ticks apart.
  - Expect done pulse 3 ticks after frame 2 is accepted, then busy=0.
- Loop plus wrap tick: loop_en=1, num_frames=1, tick_cnt wraps 99999->0 at the hold boundary.
  - Expect the wrap counted as a tick and the sequence 0,1,0,1.
  - Expect done never asserted.
- Backpressure: hold frame_ready=0 for 10 ticks in SHOW.
  - Expect frame_idx and frame_valid stable throughout.
  - Expect the hold count to start only after acceptance.
- stop and start together mid-WAIT at frame 1: expect IDLE next cycle, frame_idx=1, frame_valid=0, no done.
- Async reset asserted mid-SHOW between clock edges: expect all outputs at reset values before the next clock edge.
- With ANIM_PINGPONG_EN: num_frames=2, loop_en=1, pingpong=1 -> sequence 0,1,2,1,0,1.
